// File: rtl/llapi_pce_pad.sv
// LLAPI-to-PC Engine joypad adapter: captures receiver state, maps it to PCE buttons,
// applies autofire, serves the SEL/CLR nibble protocol and paces the receiver with LLAPI_SYNC.
module llapi_pce_pad #(
   parameter int SYNC_LEN = 64,
   parameter int STICK_LO = 64,
   parameter int STICK_HI = 192
) (
   input  logic        CLK_50M,
   input  logic        RESET_N,
   input  logic        LLAPI_EN,
   input  logic [7:0]  LLAPI_TYPE,
   input  logic [31:0] LLAPI_BUTTONS,
   input  logic [15:0] LLAPI_ANALOG,
   input  logic        VBLANK,
   input  logic        SIX_BTN,
   input  logic        TURBO_I,
   input  logic        TURBO_II,
   input  logic [1:0]  TURBO_RATE,
   input  logic        PAD_SEL,
   input  logic        PAD_CLR,
   output logic [3:0]  PAD_NIBBLE,
   output logic        LLAPI_SYNC,
   output logic [11:0] PAD_STATE
);

   localparam int          SYNC_W    = $clog2(SYNC_LEN + 1);
   localparam logic [7:0]  STICK_LO8 = 8'(STICK_LO);
   localparam logic [7:0]  STICK_HI8 = 8'(STICK_HI);

   logic              dev_now;
   logic              live;
   logic [11:0]       btn;        // {hat[27:24], face[7:0]} of the receiver vector
   logic [15:0]       axis;
   logic              vblank_q;
   logic              clr_q;
   logic              vblank_rise;
   logic              clr_rise;
   logic [1:0]        frame_cnt;
   logic              turbo_phase;
   logic [SYNC_W-1:0] sync_cnt;
   logic              bank;
   logic [3:0]        nibble_q;
   logic [3:0]        nibble_next;
   logic              up, down, left, right;
   logic              btn_i, btn_ii;
   logic              unused_bits;

   assign unused_bits = ^{LLAPI_BUTTONS[31:28], LLAPI_BUTTONS[23:8]};

   assign dev_now     = LLAPI_EN && (LLAPI_TYPE != 8'd0);
   assign vblank_rise = VBLANK && !vblank_q;
   assign clr_rise    = PAD_CLR && !clr_q;

   // Capture stage: a missing device reads as all released with a centred stick.
   always_ff @(posedge CLK_50M) begin
      if (!RESET_N) begin
         live <= 1'b0;
         btn  <= 12'h000;
         axis <= 16'h8080;
      end else if (dev_now) begin
         live <= 1'b1;
         btn  <= {LLAPI_BUTTONS[27:24], LLAPI_BUTTONS[7:0]};
         axis <= LLAPI_ANALOG;
      end else begin
         live <= 1'b0;
         btn  <= 12'h000;
         axis <= 16'h8080;
      end
   end

   always_ff @(posedge CLK_50M) begin
      if (!RESET_N) begin
         vblank_q <= 1'b0;
         clr_q    <= 1'b0;
      end else begin
         vblank_q <= VBLANK;
         clr_q    <= PAD_CLR;
      end
   end

   // Autofire: phase flips every TURBO_RATE+1 frames.
   always_ff @(posedge CLK_50M) begin
      if (!RESET_N) begin
         frame_cnt   <= 2'd0;
         turbo_phase <= 1'b0;
      end else if (vblank_rise) begin
         if (frame_cnt == TURBO_RATE) begin
            frame_cnt   <= 2'd0;
            turbo_phase <= !turbo_phase;
         end else begin
            frame_cnt <= frame_cnt + 2'd1;
         end
      end
   end

   always_ff @(posedge CLK_50M) begin
      if (!RESET_N) begin
         sync_cnt <= '0;
      end else if (vblank_rise) begin
         sync_cnt <= SYNC_W'(SYNC_LEN);
      end else if (sync_cnt != '0) begin
         sync_cnt <= sync_cnt - SYNC_W'(1);
      end
   end

   assign LLAPI_SYNC = (sync_cnt != '0);

   always_ff @(posedge CLK_50M) begin
      if (!RESET_N) begin
         bank <= 1'b0;
      end else if (!live || !SIX_BTN) begin
         bank <= 1'b0;
      end else if (clr_rise) begin
         bank <= !bank;
      end
   end

   // Hat and stick are OR-ed, then opposing directions cancel (SOCD neutral).
   always_comb begin
      up     = btn[11] || (axis[15:8] < STICK_LO8);
      down   = btn[10] || (axis[15:8] > STICK_HI8);
      left   = btn[9]  || (axis[7:0]  < STICK_LO8);
      right  = btn[8]  || (axis[7:0]  > STICK_HI8);
      if (up && down) begin
         up   = 1'b0;
         down = 1'b0;
      end
      if (left && right) begin
         left  = 1'b0;
         right = 1'b0;
      end
      btn_i  = btn[1] && (!TURBO_I  || turbo_phase);
      btn_ii = btn[0] && (!TURBO_II || turbo_phase);
   end

   assign PAD_STATE = {btn[7], btn[6], btn[2], btn[3], btn[5], btn[4],
                       btn_ii, btn_i, left, down, right, up};

   always_comb begin
      nibble_next = 4'hF;
      if (live) begin
         if (PAD_CLR) begin
            nibble_next = 4'h0;
         end else if (bank) begin
            nibble_next = PAD_SEL ? 4'h0 : ~PAD_STATE[11:8];
         end else begin
            nibble_next = PAD_SEL ? ~PAD_STATE[3:0] : ~PAD_STATE[7:4];
         end
      end
   end

   always_ff @(posedge CLK_50M) begin
      if (!RESET_N) begin
         nibble_q <= 4'hF;
      end else begin
         nibble_q <= nibble_next;
      end
   end

   assign PAD_NIBBLE = nibble_q;

endmodule

// File: tb/tb_llapi_pce_pad.sv
// Bench for llapi_pce_pad: directed protocol scenarios plus randomized traffic, all outputs
// checked each clock against a behavioural model through an expected-value queue.
module tb_llapi_pce_pad;

   localparam int SYNC_LEN = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        en;
   logic [7:0]  typ;
   logic [31:0] btn;
   logic [15:0] axis;
   logic        vblank;
   logic        six;
   logic        turbo_i;
   logic        turbo_ii;
   logic [1:0]  rate;
   logic        sel;
   logic        clr;
   logic [3:0]  nibble;
   logic        sync;
   logic [11:0] state;

   llapi_pce_pad dut (
      .CLK_50M       (clk),
      .RESET_N       (rst_n),
      .LLAPI_EN      (en),
      .LLAPI_TYPE    (typ),
      .LLAPI_BUTTONS (btn),
      .LLAPI_ANALOG  (axis),
      .VBLANK        (vblank),
      .SIX_BTN       (six),
      .TURBO_I       (turbo_i),
      .TURBO_II      (turbo_ii),
      .TURBO_RATE    (rate),
      .PAD_SEL       (sel),
      .PAD_CLR       (clr),
      .PAD_NIBBLE    (nibble),
      .LLAPI_SYNC    (sync),
      .PAD_STATE     (state)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- reference model ----------------
   // Expected entry: {sync, pad_state[11:0], nibble[3:0]} after each clock edge.
   logic [16:0] exp_q[$];

   logic        m_live;
   logic [31:0] m_btn;
   logic [15:0] m_axis;
   logic        m_vb_prev;
   logic        m_clr_prev;
   int          m_edges;
   int          m_cyc;
   int          m_last_rise;
   int          m_clr_rises;

   function automatic logic [11:0] pad_of(input logic [31:0] b, input logic [15:0] a,
                                          input logic ph, input logic ti, input logic tii);
      logic u, d, l, r, i1, i2;
      u = b[27] || (a[15:8] < 8'd64);
      d = b[26] || (a[15:8] > 8'd192);
      l = b[25] || (a[7:0]  < 8'd64);
      r = b[24] || (a[7:0]  > 8'd192);
      if (u && d) begin u = 1'b0; d = 1'b0; end
      if (l && r) begin l = 1'b0; r = 1'b0; end
      i1 = b[1] && (!ti  || ph);
      i2 = b[0] && (!tii || ph);
      return {b[7], b[6], b[2], b[3], b[5], b[4], i2, i1, l, d, r, u};
   endfunction

   // Phase after n frame edges with a fixed rate: flips every rate+1 edges.
   function automatic logic phase_of(input int n, input logic [1:0] r);
      return ((n / (int'(r) + 1)) % 2) == 1;
   endfunction

   always @(posedge clk) begin : model
      logic [11:0] st_old;
      logic [11:0] st_new;
      logic [3:0]  nib;
      logic        vrise;
      logic        crise;
      logic        sy;
      if (!rst_n) begin
         m_live      = 1'b0;
         m_btn       = 32'h0;
         m_axis      = 16'h8080;
         m_vb_prev   = 1'b0;
         m_clr_prev  = 1'b0;
         m_edges     = 0;
         m_cyc       = 0;
         m_last_rise = -100000;
         m_clr_rises = 0;
         exp_q.push_back({1'b0, 12'h000, 4'hF});
      end else begin
         st_old = pad_of(m_btn, m_axis, phase_of(m_edges, rate), turbo_i, turbo_ii);
         if (!m_live)              nib = 4'hF;
         else if (clr)             nib = 4'h0;
         else if (m_clr_rises % 2) nib = sel ? 4'h0 : ~st_old[11:8];
         else                      nib = sel ? ~st_old[3:0] : ~st_old[7:4];
         vrise = vblank && !m_vb_prev;
         crise = clr && !m_clr_prev;
         if (!m_live || !six) m_clr_rises = 0;
         else if (crise)      m_clr_rises++;
         if (vrise) begin
            m_edges++;
            m_last_rise = m_cyc;
         end
         m_vb_prev  = vblank;
         m_clr_prev = clr;
         m_live     = en && (typ != 8'd0);
         m_btn      = m_live ? btn : 32'h0;
         m_axis     = m_live ? axis : 16'h8080;
         st_new     = pad_of(m_btn, m_axis, phase_of(m_edges, rate), turbo_i, turbo_ii);
         sy         = (m_cyc - m_last_rise) < SYNC_LEN;
         m_cyc++;
         exp_q.push_back({sy, st_new, nib});
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(posedge clk) begin : monitor
      logic [16:0] e;
      #1;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL sb_underflow: actual=empty_queue required=entry t=%0t", $time);
      end else begin
         e = exp_q.pop_front();
         if (nibble !== e[3:0]) begin
            bad++;
            $display("FAIL sb_nibble: actual=%b required=%b t=%0t", nibble, e[3:0], $time);
         end
         total++;
         if (state !== e[15:4]) begin
            bad++;
            $display("FAIL sb_pad_state: actual=%h required=%h t=%0t", state, e[15:4], $time);
         end
         total++;
         if (sync !== e[16]) begin
            bad++;
            $display("FAIL sb_sync: actual=%b required=%b t=%0t", sync, e[16], $time);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick(2);
      clr = 1'b0;
      tick(2);
   endtask

   int tpat[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
   int sync_cnt;

   // ---------------- stimulus ----------------
   initial begin
      rst_n    = 1'b0;
      en       = 1'b1;
      typ      = 8'd27;
      btn      = 32'h0F00_003F;
      axis     = 16'h8080;
      vblank   = 1'b0;
      six      = 1'b0;
      turbo_i  = 1'b0;
      turbo_ii = 1'b0;
      rate     = 2'd0;
      sel      = 1'b1;
      clr      = 1'b0;

      tick(3);
      check("reset_nibble", 16'(nibble), 16'hF);
      check("reset_sync",   16'(sync),   16'h0);
      check("reset_state",  16'(state),  16'h000);
      rst_n = 1'b1;

      // 2-button read
      btn = (32'h1 << 1) | (32'h1 << 27);
      sel = 1'b1;
      tick(3);
      check("two_btn_dpad_up", 16'(nibble), 16'hE);
      sel = 1'b0;
      tick(2);
      check("two_btn_button_i", 16'(nibble), 16'hE);

      // Analog stick: X=10 (left), Y=250 (down)
      btn  = 32'h0;
      axis = {8'd250, 8'd10};
      sel  = 1'b1;
      tick(3);
      check("analog_left_down", 16'(nibble), 16'h3);

      // SOCD on hat with centred stick
      axis = 16'h8080;
      btn  = (32'h1 << 27) | (32'h1 << 26);
      tick(3);
      check("socd_state", 16'(state[3:0]), 16'h0);
      check("socd_nibble", 16'(nibble), 16'hF);

      // 6-button: VI and right held
      six = 1'b1;
      btn = (32'h1 << 7) | (32'h1 << 24);
      sel = 1'b1;
      tick(3);
      check("six_bank0_dpad", 16'(nibble), 16'hD);
      pulse_clr();
      check("six_bank1_id", 16'(nibble), 16'h0);
      sel = 1'b0;
      tick(2);
      check("six_bank1_ext", 16'(nibble), 16'h7);
      pulse_clr();
      sel = 1'b1;
      tick(2);
      check("six_back_bank0", 16'(nibble), 16'hD);

      // Disconnect while in bank 1
      pulse_clr();
      check("disc_pre_bank1", 16'(nibble), 16'h0);
      en = 1'b0;
      tick(2);
      for (int s = 0; s < 2; s++) begin
         for (int c = 0; c < 2; c++) begin
            sel = 1'(s);
            clr = 1'(c);
            tick(2);
            check("disc_nibble", 16'(nibble), 16'hF);
         end
      end
      clr = 1'b0;
      en  = 1'b1;
      sel = 1'b1;
      tick(3);
      check("reconnect_bank0", 16'(nibble), 16'hD);

      // Turbo on I at rate 1 with sync pulse width
      six     = 1'b0;
      turbo_i = 1'b1;
      rate    = 2'd1;
      btn     = 32'h1 << 1;
      do_reset();
      tick(3);
      for (int f = 0; f < 8; f++) begin
         check("turbo_phase_i", 16'(state[4]), 16'(tpat[f]));
         vblank   = 1'b1;
         sync_cnt = 0;
         tick(1);
         if (sync) sync_cnt++;
         vblank = 1'b0;
         repeat (90) begin
            tick(1);
            if (sync) sync_cnt++;
         end
         check("sync_width", 16'(sync_cnt), 16'(SYNC_LEN));
      end
      turbo_i = 1'b0;

      // Randomized traffic; turbo rate only changes across resets
      for (int seg = 0; seg < 4; seg++) begin
         rate     = 2'($urandom_range(0, 3));
         turbo_i  = 1'($urandom_range(0, 1));
         turbo_ii = 1'($urandom_range(0, 1));
         six      = (seg != 0);
         en       = 1'b1;
         typ      = 8'd27;
         do_reset();
         for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) == 0) en = ~en;
            if ($urandom_range(0, 199) == 0) typ = (typ == 8'd0) ? 8'($urandom_range(1, 255)) : 8'd0;
            if ($urandom_range(0, 3) == 0) btn = $urandom;
            if ($urandom_range(0, 3) == 0) axis = 16'($urandom);
            if ($urandom_range(0, 2) == 0) sel = ~sel;
            clr    = ($urandom_range(0, 7) == 0);
            vblank = ($urandom_range(0, 99) < 3);
            tick(1);
         end
      end

      vblank = 1'b0;
      clr    = 1'b0;
      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
